// File: rtl/i2c_master_arbiter_pkg.sv
// i2c_arb_pkg: shared types and widths for the i2c master arbiter.
package i2c_arb_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE} arb_state_e;
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester-side and core-side signals of the arbiter.
interface i2c_master_arbiter_if
  import i2c_arb_pkg::*;
#(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req, lock, req_rw, gnt, rsp_valid;
  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;
  logic [I2C_DATA_W-1:0] rsp_rdata, i2c_data_in, i2c_rdata;
  logic [I2C_ADDR_W-1:0] i2c_slave_address;
  logic rsp_err, i2c_enable, i2c_rw, i2c_repeated_start, i2c_busy, i2c_done, i2c_nack;
  modport slave (
    input req, lock, req_addr, req_rw, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err, i2c_enable, i2c_slave_address, i2c_data_in,
    i2c_rw, i2c_repeated_start
  );
  modport master (
    output req, lock, req_addr, req_rw, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    input gnt, rsp_valid, rsp_rdata, rsp_err, i2c_enable, i2c_slave_address, i2c_data_in,
    i2c_rw, i2c_repeated_start
  );
endinterface

// File: rtl/i2c_master_arbiter_rr_picker.sv
// i2c_rr_picker: combinational round-robin pick starting after last_gnt_i.
module i2c_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_gnt_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);
  // Scan farthest-first so the nearest requester after last_gnt_i overwrites.
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_i[(int'(last_gnt_i) + k) % NUM_REQ]) idx_o = IDX_W'((int'(last_gnt_i) + k) % NUM_REQ);
    win_o = |req_i ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c controller with lock chaining and watchdog.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rst,
  i2c_master_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, pick_win;
  logic [IDX_W-1:0] owner_q, last_q, pick_idx, sel;
  logic [TMR_W-1:0] timer_q;
  logic [I2C_ADDR_W-1:0] addr_q;
  logic [I2C_DATA_W-1:0] wdata_q, rdata_q;
  logic lock_valid_q, rw_q, rs_q, err_q;
  logic grant_new, grant_lock, unlock, waiting, timeout, capture, keep;

  i2c_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i(bus.req), .last_gnt_i(last_q), .win_o(pick_win), .idx_o(pick_idx)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    grant_new = state_q == IDLE && !lock_valid_q && |bus.req;
    grant_lock = state_q == IDLE && lock_valid_q && bus.req[owner_q];
    unlock = state_q == IDLE && lock_valid_q && !bus.req[owner_q] && !bus.lock[owner_q];
    waiting = state_q == WAIT_BUSY || state_q == WAIT_DONE;
    timeout = timer_q == TMR_W'(TIMEOUT_CYCLES - 1);
    capture = waiting && (bus.i2c_done || timeout);
    keep = bus.lock[owner_q] && !err_q;
    sel = grant_lock ? owner_q : pick_idx;
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = grant_new || grant_lock ? LAUNCH : IDLE;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = capture ? COMPLETE : bus.i2c_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = capture ? COMPLETE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end

  // Payload is captured only at grant; a locked owner is re-granted with repeated start.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt_q <= '0;
      owner_q <= '0;
      last_q <= IDX_W'(NUM_REQ - 1);
      lock_valid_q <= 1'b0;
      timer_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rw_q <= 1'b0;
      rs_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_new || grant_lock) begin
        gnt_q <= grant_lock ? gnt_q : pick_win;
        owner_q <= sel;
        addr_q <= bus.req_addr[I2C_ADDR_W*int'(sel) +: I2C_ADDR_W];
        wdata_q <= bus.req_wdata[I2C_DATA_W*int'(sel) +: I2C_DATA_W];
        rw_q <= bus.req_rw[sel];
        rs_q <= grant_lock;
      end
      if (unlock) begin
        lock_valid_q <= 1'b0;
        gnt_q <= '0;
      end
      timer_q <= state_q == LAUNCH ? '0 :
                 waiting && timer_q != TMR_W'(TIMEOUT_CYCLES) ? timer_q + 1'b1 : timer_q;
      if (capture) begin
        rdata_q <= bus.i2c_done && rw_q ? bus.i2c_rdata : '0;
        err_q <= bus.i2c_done ? bus.i2c_nack : 1'b1;
      end
      if (state_q == COMPLETE) begin
        last_q <= owner_q;
        lock_valid_q <= keep;
        if (!keep) gnt_q <= '0;
      end
    end

  always_comb begin
    bus.gnt = gnt_q;
    bus.rsp_valid = state_q == COMPLETE ? gnt_q : '0;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err = err_q;
    bus.i2c_enable = state_q == LAUNCH;
    bus.i2c_slave_address = addr_q;
    bus.i2c_data_in = wdata_q;
    bus.i2c_rw = rw_q;
    bus.i2c_repeated_start = rs_q;
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed scenarios checked against a transfer-level timeline model.
module tb_i2c_master_arbiter;
  localparam int N = 2;
  localparam int TO = 16;
  logic clk = 0, rst = 1;
  int n_checks = 0, n_errors = 0;
  int c_busy = 0, c_done = 0;
  logic c_nack = 0;
  logic [7:0] c_rdata = 0;
  logic [1:0] m_gnt = 0, m_rv = 0;
  logic [7:0] m_rdata = 0, m_data = 0;
  logic [6:0] m_addr = 0;
  logic m_err = 0, m_en = 0, m_rw = 0, m_rs = 0;
  time en_t = 0;
  int lat;
  logic [1:0] v;

  i2c_master_arbiter_if #(.NUM_REQ(N)) bus ();
  i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic tick(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  task automatic m_clear();
    m_gnt = 0; m_rv = 0; m_rdata = 0; m_data = 0; m_addr = 0;
    m_err = 0; m_en = 0; m_rw = 0; m_rs = 0;
  endtask

  // Model: one transfer = grant edge, launch cycle, wait until done or TO cycles, one response cycle.
  task automatic model_run();
    int last = N - 1, owner = 0, n;
    bit locked = 0, ab;
    forever begin
      tick(ab); if (ab) return;
      if (locked) begin
        if (!bus.req[owner]) begin
          if (!bus.lock[owner]) begin locked = 0; m_gnt = 0; end
          continue;
        end
        m_rs = 1;
      end else begin
        if (bus.req == 0) continue;
        owner = rr_pick(bus.req, last);
        m_rs = 0;
      end
      m_gnt = 0;
      m_gnt[owner] = 1;
      m_addr = bus.req_addr[7*owner +: 7];
      m_data = bus.req_wdata[8*owner +: 8];
      m_rw = bus.req_rw[owner];
      m_en = 1;
      tick(ab); if (ab) return;
      m_en = 0;
      n = 0;
      forever begin
        tick(ab); if (ab) return;
        if (bus.i2c_done) begin m_rdata = m_rw ? bus.i2c_rdata : 8'h00; m_err = bus.i2c_nack; break; end
        if (n == TO - 1) begin m_rdata = 0; m_err = 1; break; end
        n++;
      end
      m_rv = m_gnt;
      tick(ab); if (ab) return;
      m_rv = 0;
      last = owner;
      locked = bus.lock[owner] && !m_err;
      if (!locked) m_gnt = 0;
    end
  endtask

  initial forever begin
    m_clear();
    wait (!rst);
    model_run();
  end

  always @(negedge clk) begin
    chk("gnt", bus.gnt, m_gnt);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("rsp_err", bus.rsp_err, m_err);
    chk("i2c_enable", bus.i2c_enable, m_en);
    chk("i2c_addr", bus.i2c_slave_address, m_addr);
    chk("i2c_data_in", bus.i2c_data_in, m_data);
    chk("i2c_rw", bus.i2c_rw, m_rw);
    chk("i2c_rs", bus.i2c_repeated_start, m_rs);
    if (bus.i2c_enable) en_t = $time;
  end

  // Core emulation: busy from cycle c_busy, one-cycle done at cycle c_done after the enable cycle.
  initial begin
    int lim;
    bus.i2c_busy = 0; bus.i2c_done = 0; bus.i2c_nack = 0; bus.i2c_rdata = 0;
    forever begin
      @(negedge clk);
      if (bus.i2c_enable === 1'b1) begin
        lim = c_done != 0 ? c_done : 24;
        for (int k = 1; k <= lim; k++) begin
          @(posedge clk); #1;
          if (rst) break;
          bus.i2c_busy = c_busy != 0 && k >= c_busy && k != c_done;
          bus.i2c_done = k == c_done;
          bus.i2c_nack = k == c_done && c_nack;
          bus.i2c_rdata = k == c_done ? c_rdata : 8'h5A;
        end
        @(posedge clk); #1;
        bus.i2c_busy = 0; bus.i2c_done = 0; bus.i2c_nack = 0; bus.i2c_rdata = 0;
      end
    end
  end

  task automatic set_req(int i, logic [6:0] a, logic [7:0] d, logic rw);
    bus.req_addr[7*i +: 7] = a;
    bus.req_wdata[8*i +: 8] = d;
    bus.req_rw[i] = rw;
  endtask

  task automatic wait_rsp(output int l, output logic [1:0] r);
    l = -1;
    r = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 0) begin
        r = bus.rsp_valid;
        l = int'(($time - en_t) / 10);
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL rsp_wait: no rsp_valid within 60 cycles at %0t", $time);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 0; bus.lock = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_rw = 0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", bus.gnt, 2'b00);
    chk("reset_en", bus.i2c_enable, 1'b0);
    rst = 0;
    // Single write; payload changed mid-transfer must be ignored.
    c_busy = 3; c_done = 10; c_nack = 0;
    set_req(0, 7'h6B, 8'hAA, 1'b0);
    bus.req = 2'b01;
    repeat (3) @(negedge clk);
    set_req(0, 7'h11, 8'h00, 1'b0);
    wait_rsp(lat, v);
    chk("wr_lat", lat, 11);
    chk("wr_v", v, 2'b01);
    chk("wr_err", bus.rsp_err, 1'b0);
    chk("wr_addr", bus.i2c_slave_address, 7'h6B);
    chk("wr_data", bus.i2c_data_in, 8'hAA);
    bus.req = 0;
    // Read by requester 1.
    c_busy = 2; c_done = 5; c_rdata = 8'h3C;
    set_req(1, 7'h50, 8'h00, 1'b1);
    bus.req = 2'b10;
    wait_rsp(lat, v);
    chk("rd_lat", lat, 6);
    chk("rd_v", v, 2'b10);
    chk("rd_rdata", bus.rsp_rdata, 8'h3C);
    bus.req = 0;
    // Fairness with both requesting.
    c_busy = 1; c_done = 3;
    set_req(0, 7'h6B, 8'h01, 1'b0);
    set_req(1, 7'h50, 8'h02, 1'b0);
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(lat, v);
      chk("fair_v", v, i % 2 == 1 ? 2'b10 : 2'b01);
    end
    chk("fair_wr_rdata", bus.rsp_rdata, 8'h00);
    bus.req = 0;
    // Lock chain: write then repeated-start read by requester 0 while requester 1 waits.
    set_req(0, 7'h22, 8'h33, 1'b0);
    set_req(1, 7'h44, 8'h55, 1'b1);
    bus.lock = 2'b01;
    bus.req = 2'b11;
    wait_rsp(lat, v);
    chk("lk1_v", v, 2'b01);
    chk("lk1_rs", bus.i2c_repeated_start, 1'b0);
    set_req(0, 7'h23, 8'h34, 1'b1);
    c_rdata = 8'h77;
    wait_rsp(lat, v);
    chk("lk2_v", v, 2'b01);
    chk("lk2_rs", bus.i2c_repeated_start, 1'b1);
    chk("lk2_addr", bus.i2c_slave_address, 7'h23);
    chk("lk2_rdata", bus.rsp_rdata, 8'h77);
    bus.req = 2'b10;
    repeat (3) @(negedge clk);
    chk("lk_hold_gnt", bus.gnt, 2'b01);
    bus.lock = 2'b00;
    wait_rsp(lat, v);
    chk("lk3_v", v, 2'b10);
    chk("lk3_rs", bus.i2c_repeated_start, 1'b0);
    chk("lk3_lat", lat, 4);
    bus.req = 0;
    // Done arriving on the last timer cycle beats the timeout.
    c_busy = 1; c_done = 16; c_rdata = 8'hC3;
    set_req(0, 7'h0F, 8'h00, 1'b1);
    bus.req = 2'b01;
    wait_rsp(lat, v);
    chk("edge_lat", lat, 17);
    chk("edge_err", bus.rsp_err, 1'b0);
    chk("edge_rdata", bus.rsp_rdata, 8'hC3);
    bus.req = 0;
    repeat (4) @(negedge clk);
    // Timeout with a silent core.
    c_busy = 0; c_done = 0;
    bus.req = 2'b01;
    wait_rsp(lat, v);
    chk("to_lat", lat, 17);
    chk("to_err", bus.rsp_err, 1'b1);
    chk("to_rdata", bus.rsp_rdata, 8'h00);
    bus.req = 0;
    repeat (12) @(negedge clk);
    // NACK while locked releases the bus.
    c_busy = 1; c_done = 4; c_nack = 1;
    set_req(0, 7'h2A, 8'h99, 1'b0);
    bus.lock = 2'b01;
    bus.req = 2'b01;
    wait_rsp(lat, v);
    chk("nack_v", v, 2'b01);
    chk("nack_err", bus.rsp_err, 1'b1);
    bus.req = 0;
    @(negedge clk);
    chk("nack_gnt", bus.gnt, 2'b00);
    bus.lock = 0;
    c_nack = 0;
    // Asynchronous reset in the middle of a transfer.
    c_busy = 2; c_done = 12;
    bus.req = 2'b01;
    repeat (6) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_gnt", bus.gnt, 2'b00);
    chk("arst_addr", bus.i2c_slave_address, 7'h00);
    chk("arst_rs", bus.rsp_valid, 2'b00);
    bus.req = 2'b11;
    c_done = 3;
    repeat (2) @(negedge clk);
    rst = 0;
    wait_rsp(lat, v);
    chk("arst_first_v", v, 2'b01);
    bus.req = 0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
